timer_seq: RTL

Multi-phase sequencer that drives the controller side of a `timer` instance. It replays a programmable schedule of up to `NPHASE` timed phases, one-shot or continuous, for example pixel-reset / integrate / readout windows in the DVS readout path. The block owns the timer's `load`, `enable`, `load_value` and `threshold` inputs and consumes its `flag`. It reports phase and sequence completion to downstream logic.

---
 rtl/timer_seq.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/timer_seq.sv
// timer_seq: replays a schedule of up to NPHASE timed phases on an attached timer.
// Optional pause support is compiled in with `define TIMER_SEQ_PAUSE_EN.
module timer_seq #(
    parameter  int DWIDTH = 8,
    parameter  int NPHASE = 4,
    localparam int PW     = $clog2(NPHASE + 1)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic                           stop,
    input  logic                           pause,
    input  logic                           mode_cont,
    input  logic [PW-1:0]                  num_phases,
    input  logic [NPHASE-1:0][DWIDTH-1:0]  phase_thr,
    input  logic                           tmr_flag,
    output logic                           tmr_load,
    output logic                           tmr_enable,
    output logic [DWIDTH-1:0]              tmr_load_value,
    output logic [DWIDTH-1:0]              tmr_threshold,
    output logic [PW-1:0]                  phase_idx,
    output logic                           phase_done,
    output logic                           seq_done,
    output logic                           busy,
    output logic [15:0]                    seq_count
);

`ifdef TIMER_SEQ_PAUSE_EN
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_PAUSED} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN} state_t;
    logic pause_unused;
    assign pause_unused = pause;
`endif

    state_t             state_q, state_d;
    logic [PW-1:0]      nph_q, nph_clamped;
    logic               mode_q;
    logic [PW-1:0]      idx_q, idx_d;
    logic [DWIDTH-1:0]  thr_q, thr_sel;
    logic               thr_ld, cfg_ld;
    logic               pdone_d, sdone_d, pdone_q, sdone_q;
    logic               cnt_inc, cnt_clr;
    logic [15:0]        cnt_q;
    logic               last_phase, run_go;

    always_comb begin
        nph_clamped = num_phases;
        if (num_phases == '0)
            nph_clamped = PW'(1);
        else if (num_phases > PW'(NPHASE))
            nph_clamped = PW'(NPHASE);
    end

    assign last_phase = (idx_q == nph_q - PW'(1));

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        thr_ld  = 1'b0;
        cfg_ld  = 1'b0;
        pdone_d = 1'b0;
        sdone_d = 1'b0;
        cnt_inc = 1'b0;
        cnt_clr = 1'b0;
        run_go  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD;
                    cfg_ld  = 1'b1;
                    cnt_clr = 1'b1;
                    idx_d   = '0;
                    thr_ld  = 1'b1;
                end
            end
            S_LOAD: begin
`ifdef TIMER_SEQ_PAUSE_EN
                state_d = pause ? S_PAUSED : S_RUN;
`else
                state_d = S_RUN;
`endif
            end
            S_RUN: begin
`ifdef TIMER_SEQ_PAUSE_EN
                // Pause wins over a coincident flag; the held flag is seen after resume.
                run_go = tmr_flag && !pause;
                if (pause)
                    state_d = S_PAUSED;
`else
                run_go = tmr_flag;
`endif
                if (run_go) begin
                    pdone_d = 1'b1;
                    if (last_phase) begin
                        sdone_d = 1'b1;
                        cnt_inc = 1'b1;
                        if (mode_q) begin
                            idx_d   = '0;
                            thr_ld  = 1'b1;
                            state_d = S_LOAD;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        idx_d   = idx_q + PW'(1);
                        thr_ld  = 1'b1;
                        state_d = S_LOAD;
                    end
                end
            end
`ifdef TIMER_SEQ_PAUSE_EN
            S_PAUSED: begin
                if (!pause)
                    state_d = S_RUN;
            end
`endif
            default: state_d = S_IDLE;
        endcase

        // Abort drops any pending completion and freezes index, threshold and count.
        if (stop) begin
            state_d = S_IDLE;
            idx_d   = idx_q;
            thr_ld  = 1'b0;
            cfg_ld  = 1'b0;
            pdone_d = 1'b0;
            sdone_d = 1'b0;
            cnt_inc = 1'b0;
            cnt_clr = 1'b0;
        end
    end

    always_comb begin
        thr_sel = '0;
        for (int i = 0; i < NPHASE; i++)
            if (idx_d == PW'(i))
                thr_sel = phase_thr[i];
    end

    always_ff @(posedge clk) begin
        if (rst)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q   <= '0;
            thr_q   <= '0;
            pdone_q <= 1'b0;
            sdone_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            idx_q   <= idx_d;
            pdone_q <= pdone_d;
            sdone_q <= sdone_d;
            if (thr_ld)
                thr_q <= thr_sel;
            if (cnt_clr)
                cnt_q <= '0;
            else if (cnt_inc)
                cnt_q <= cnt_q + 16'd1;
        end
    end

    // Sequence configuration is only meaningful after a start, so it carries no reset.
    always_ff @(posedge clk) begin
        if (cfg_ld) begin
            nph_q  <= nph_clamped;
            mode_q <= mode_cont;
        end
    end

    assign tmr_load       = (state_q == S_LOAD);
    assign tmr_enable     = (state_q == S_RUN);
    assign busy           = (state_q != S_IDLE);
    assign tmr_load_value = '0;
    assign tmr_threshold  = thr_q;
    assign phase_idx      = idx_q;
    assign phase_done     = pdone_q;
    assign seq_done       = sdone_q;
    assign seq_count      = cnt_q;

endmodule
